// File: rtl/stack_pop_reader_if.sv
// -----------------------------------------------------------------------------
// stack_pop_reader_if
//   Receive (pop) side of the stack: a 4-phase handshake plus data and the
//   empty indicator.
//
//   Signals
//     rx_rdy    stack -> reader  a word is present on out_data
//     out_data  stack -> reader  pop data, valid while rx_rdy = 1
//     empty     stack -> reader  stack holds no words
//     rx_done   reader -> stack  handshake acknowledge
//
//   Modports
//     master  the stack (drives rx_rdy / out_data / empty)
//     slave   the pop reader (drives rx_done)
// -----------------------------------------------------------------------------
interface stack_pop_reader_if #(
  parameter int WIDTH = 8
) ();

  logic             rx_rdy;
  logic [WIDTH-1:0] out_data;
  logic             empty;
  logic             rx_done;

  modport master (
    output rx_rdy,
    output out_data,
    output empty,
    input  rx_done
  );

  modport slave (
    input  rx_rdy,
    input  out_data,
    input  empty,
    output rx_done
  );

endinterface : stack_pop_reader_if

// File: rtl/stack_pop_reader.sv
// -----------------------------------------------------------------------------
// stack_pop_reader
//   Consumer-side handshake engine for the stack's pop interface. A start
//   command pops burst_len_i words with the 4-phase rx handshake. Every popped
//   word is presented once on rd_data_o with a one-cycle rd_valid_o strobe,
//   and a running word count and modular checksum are kept. A burst ends
//   early when the stack runs empty (underflow) or when rx_rdy is not
//   released within TIMEOUT cycles of rx_done rising (timeout).
//
//   Parameters
//     WIDTH      data word width (matches the stack's out_data)
//     MAX_WORDS  largest burst length; sets CW = $clog2(MAX_WORDS+1)
//     TIMEOUT    cycles rx_rdy may stay high after rx_done rises
//
//   Ports
//     clk            system clock, rising edge
//     rst            asynchronous active-high reset
//     start_i        begin a burst (sampled only while idle)
//     burst_len_i    words to pop, sampled with start_i
//     rx             pop handshake (slave side; drives rx_done)
//     rd_data_o      last popped word
//     rd_valid_o     one-cycle strobe, rd_data_o is new
//     words_read_o   words popped in the current or last burst
//     checksum_o     sum mod 2^WIDTH of the words popped this burst
//     busy_o         high whenever the engine is not idle
//     done_o         one-cycle pulse at burst end (normal or abort)
//     underflow_o    sticky: the burst ended because the stack ran empty
//     timeout_err_o  sticky: the burst ended because rx_rdy never released
// -----------------------------------------------------------------------------
module stack_pop_reader #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16,
  parameter int TIMEOUT   = 64,
  localparam int CW       = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [CW-1:0]         burst_len_i,
  stack_pop_reader_if.slave     rx,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_valid_o,
  output logic [CW-1:0]         words_read_o,
  output logic [WIDTH-1:0]      checksum_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  underflow_o,
  output logic                  timeout_err_o
);

  // Timeout counter only has to reach TIMEOUT-1; keep at least one bit.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_WAIT_REL = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  // Modular checksum accumulate; the carry out of the top bit is dropped.
  function automatic logic [WIDTH-1:0] csum_add(
    input logic [WIDTH-1:0] acc,
    input logic [WIDTH-1:0] word
  );
    return acc + word;
  endfunction

  state_t           state_q;
  logic [CW-1:0]    len_q;
  logic [TW-1:0]    tmo_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic [CW-1:0]    words_read_q;
  logic [WIDTH-1:0] checksum_q;
  logic             busy_q;
  logic             done_q;
  logic             underflow_q;
  logic             timeout_err_q;
  logic             rx_done_q;

  // Next-value helpers used by the state machine.
  logic [CW-1:0]    words_read_d;
  logic [WIDTH-1:0] checksum_d;
  logic [TW-1:0]    tmo_d;

  // Increment / accumulate values for the word currently offered by the stack.
  always_comb begin
    words_read_d = words_read_q + CW'(1);
    checksum_d   = csum_add(checksum_q, rx.out_data);
    tmo_d        = tmo_q + TW'(1);
  end

  // Burst state machine; every output is a register written here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      tmo_q         <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      words_read_q  <= '0;
      checksum_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      underflow_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      rx_done_q     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            len_q         <= burst_len_i;
            words_read_q  <= '0;
            checksum_q    <= '0;
            underflow_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            tmo_q         <= '0;
            busy_q        <= 1'b1;
            // A zero-length burst still reports completion through DONE.
            if (burst_len_i == '0) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_WAIT_RDY;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_WAIT_RDY: begin
          // A present word wins over the empty flag in the same cycle.
          if (rx.rx_rdy) begin
            rd_data_q    <= rx.out_data;
            rd_valid_q   <= 1'b1;
            checksum_q   <= checksum_d;
            words_read_q <= words_read_d;
            rx_done_q    <= 1'b1;
            tmo_q        <= '0;
            state_q      <= ST_WAIT_REL;
          end else if (rx.empty) begin
            underflow_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            state_q <= ST_WAIT_RDY;
          end
        end

        ST_WAIT_REL: begin
          // rx_done stays high until the stack drops rx_rdy or we give up.
          if (!rx.rx_rdy) begin
            rx_done_q <= 1'b0;
            if (words_read_q == len_q) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_WAIT_RDY;
            end
          end else if (tmo_q == TMO_LAST) begin
            rx_done_q     <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= ST_DONE;
          end else begin
            tmo_q   <= tmo_d;
            state_q <= ST_WAIT_REL;
          end
        end

        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          rx_done_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx.rx_done    = rx_done_q;
  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;
  assign words_read_o  = words_read_q;
  assign checksum_o    = checksum_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign underflow_o   = underflow_q;
  assign timeout_err_o = timeout_err_q;

endmodule : stack_pop_reader

// File: doc/stack_pop_reader.md
Name: stack_pop_reader

Overview:
- Consumer-side handshake engine for the stack's receive (pop) interface: rx_rdy/rx_done/out_data, plus the empty indicator.
- On a start command it pops a programmed number of words using the 4-phase rx handshake.
- Each popped word is presented to downstream logic with a one-cycle valid strobe.
- It keeps a running word count and modular checksum, and flags underflow (stack ran empty) and handshake timeout.

Parameters:
- WIDTH, 8, data word width; must match the stack's out_data.
- MAX_WORDS, 16, largest burst length; burst_len width is CW = $clog2(MAX_WORDS+1).
- TIMEOUT, 64, cycles rx_rdy may stay high after rx_done is raised before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin burst; sampled only in IDLE.
- burst_len  in  CW  words to pop; sampled with start.
- rx_rdy  in  1  stack has a word on out_data.
- out_data  in  WIDTH  stack pop data; valid while rx_rdy=1.
- empty  in  1  stack empty indicator.
- rx_done  out  1  handshake acknowledge to the stack.
- rd_data  out  WIDTH  last popped word.
- rd_valid  out  1  one-cycle strobe; rd_data is new.
- words_read  out  CW  words popped in the current or last burst.
- checksum  out  WIDTH  sum mod 2^WIDTH of words popped this burst.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at burst end, for normal end or abort.
- underflow  out  1  sticky; burst ended because the stack ran empty.
- timeout_err  out  1  sticky; burst ended because rx_rdy never released.

Behaviour:
- Reset (async): state=IDLE; every output is 0, including rx_done. Internal timeout counter = 0. Applies mid-burst; a partial burst is discarded.
- All outputs are registered. States: IDLE, WAIT_RDY, WAIT_REL, DONE.
- IDLE:
  - On start=1, latch burst_len.
  - Clear words_read, checksum, underflow, timeout_err.
  - If burst_len=0, go to DONE. Otherwise go to WAIT_RDY.
  - start is ignored in every state except IDLE.
- WAIT_RDY:
  - If rx_rdy=1: rd_data<=out_data; rd_valid<=1; checksum<=checksum+out_data (wrap mod 2^WIDTH); words_read<=words_read+1; rx_done<=1; clear timeout counter; go to WAIT_REL.
  - Else if empty=1: underflow<=1; go to DONE.
  - rx_rdy takes priority over empty in the same cycle.
- WAIT_REL:
  - rx_done is held at 1.
  - If rx_rdy=0: rx_done<=0. If words_read==latched length, go to DONE; else go to WAIT_RDY.
  - Else increment the timeout counter. When it reaches TIMEOUT-1: rx_done<=0; timeout_err<=1; go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. words_read, checksum, rd_data and the flags hold until the next start.
- rd_valid is 1 for exactly one cycle per popped word, in the cycle after rx_rdy is sampled high, coincident with rx_done rising.
- Handshake rules:
  - rx_done never rises unless rx_rdy was sampled high the previous edge.
  - rx_done never falls while rx_rdy=1, except on timeout abort or reset.
- Minimum pop period is 3 cycles: WAIT_RDY sample, WAIT_REL sees rx_rdy low, WAIT_RDY again.
- A burst_len above MAX_WORDS cannot be represented beyond the CW range. A value in range but above MAX_WORDS is popped as given; no clamp.

Test Plan:
1. Stack preloaded 10,20,30 (pop order 30,20,10); start with burst_len=3. Required: rd_data 30,20,10 on three rd_valid strobes; words_read=3; checksum=60; done pulses once; underflow=0; rx_done ends 0.
2. Stack holds 2 words (5,7 popped as 7,5); burst_len=4. Required: two pops; empty seen in WAIT_RDY; underflow=1; words_read=2; checksum=12; done pulses.
3. WIDTH=8, pop 200 then 100. Required: checksum=44 (300 mod 256).
4. burst_len=0. Required: done pulses 2 cycles after start; rx_done never asserts; words_read=0.
5. Model holds rx_rdy=1 indefinitely after rx_done rises, with TIMEOUT=64. Required: rx_done drops after 64 cycles in WAIT_REL; timeout_err=1; done pulses; words_read=1.
6. Assert rst mid-burst while rx_done=1. Required: rx_done, busy, rd_valid go 0 immediately, without waiting for a clock edge. After release, a new start with burst_len=1 completes normally. A start pulse while busy is ignored (burst length unchanged).
